// File: rtl/uart2wb.sv
// ASCII command parser: turns "R"/"W" + 8 hex digits from the UART receiver into
// 34-bit bus command words, held in a one-entry register until the bus master takes them.
module uart2wb #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_DataByte,
  input  logic                 in_fValid,
  output logic [33:0]          out_UART2WB_word,
  output logic                 out_UART2WB_cyc,
  input  logic                 in_UART2WB_stall,
  output logic                 out_Error,
  output logic [ERR_CNT_W-1:0] out_ErrCount,
  output logic                 out_Busy
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {S_IDLE, S_DATA} state_t;

  state_t           state;
  logic             is_write;
  logic [31:0]      shift;
  logic [2:0]       nib_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic       is_hex;
  logic       is_cmd;
  logic [3:0] nib;
  logic       accept;
  logic       frame_done;
  logic       frame_err;
  logic       timeout_hit;
  logic       drop;
  logic       err_evt;

  // Letters map to 10..15 via their low nibble: 'a'/'A' have low nibble 1.
  always_comb begin
    is_hex = 1'b1;
    nib    = 4'h0;
    if (in_DataByte >= 8'h30 && in_DataByte <= 8'h39)
      nib = in_DataByte[3:0];
    else if ((in_DataByte >= 8'h61 && in_DataByte <= 8'h66) ||
             (in_DataByte >= 8'h41 && in_DataByte <= 8'h46))
      nib = in_DataByte[3:0] + 4'd9;
    else
      is_hex = 1'b0;
  end

  assign is_cmd      = (in_DataByte == 8'h52) || (in_DataByte == 8'h57);
  assign accept      = out_UART2WB_cyc && !in_UART2WB_stall;
  assign frame_done  = (state == S_DATA) && in_fValid && is_hex && (nib_cnt == 3'd7);
  assign frame_err   = (state == S_DATA) && in_fValid && !is_hex;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == S_DATA) && !in_fValid &&
                       (tmo_cnt == TMO_LAST);
  assign drop        = frame_done && out_UART2WB_cyc && !accept;
  assign err_evt     = drop || frame_err || timeout_hit;
  assign out_Busy    = (state == S_DATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      is_write         <= 1'b0;
      shift            <= 32'h0;
      nib_cnt          <= 3'd0;
      tmo_cnt          <= '0;
      out_UART2WB_word <= 34'h0;
      out_UART2WB_cyc  <= 1'b0;
      out_Error        <= 1'b0;
      out_ErrCount     <= '0;
    end else begin
      out_Error <= err_evt;
      if (err_evt && (out_ErrCount != '1))
        out_ErrCount <= out_ErrCount + 1'b1;

      // A completed frame may load only if the slot is empty or draining this cycle.
      if (frame_done && (!out_UART2WB_cyc || accept)) begin
        out_UART2WB_word <= {1'b0, is_write, shift[27:0], nib};
        out_UART2WB_cyc  <= 1'b1;
      end else if (accept) begin
        out_UART2WB_cyc  <= 1'b0;
      end

      if ((state == S_IDLE) || in_fValid)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (in_fValid && is_cmd) begin
            is_write <= (in_DataByte == 8'h57);
            shift    <= 32'h0;
            nib_cnt  <= 3'd0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (in_fValid) begin
            if (is_hex) begin
              shift   <= {shift[27:0], nib};
              nib_cnt <= nib_cnt + 3'd1;
              if (nib_cnt == 3'd7)
                state <= S_IDLE;
            end else if (is_cmd) begin
              is_write <= (in_DataByte == 8'h57);
              shift    <= 32'h0;
              nib_cnt  <= 3'd0;
            end else begin
              state <= S_IDLE;
            end
          end else if (timeout_hit) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart2wb.sv
// Bench for uart2wb: frame vectors, hand-written corner sequences and a random
// character stream checked against a char-level parser model.
module tb_uart2wb;

  localparam int TMO = 50;
  localparam int ECW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     in_data = 8'h0;
  logic           in_valid = 1'b0;
  logic [33:0]    word;
  logic           cyc;
  logic           stall = 1'b0;
  logic           err;
  logic [ECW-1:0] err_cnt;
  logic           busy;

  uart2wb #(.TIMEOUT_CYCLES(TMO), .ERR_CNT_W(ECW)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_DataByte      (in_data),
    .in_fValid        (in_valid),
    .out_UART2WB_word (word),
    .out_UART2WB_cyc  (cyc),
    .in_UART2WB_stall (stall),
    .out_Error        (err),
    .out_ErrCount     (err_cnt),
    .out_Busy         (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int m_err = 0;
  logic [33:0] exp_q[$];

  // char-level reference parser state
  bit  m_busy = 1'b0;
  bit  m_w = 1'b0;
  int  m_nibs[$];

  typedef struct {
    string       s;
    bit          has_word;
    logic [33:0] word;
    int          errs;
  } vec_t;
  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat_cnt(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // scoreboard: every transfer (cyc && !stall) must match the oldest expected word
  always @(negedge clk) begin
    if (!rst) begin
      if (err) err_seen++;
      if (cyc && !stall) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: got %0h expected none", word);
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          if (word !== e) begin
            failures++;
            $display("FAIL word: got %0h expected %0h", word, e);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks: called at posedge+1, return at posedge+1
  task automatic send_char(input byte c, input int gap);
    in_data  = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i], 0);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic add_vec(input string s, input bit hw, input logic [33:0] w, input int e);
    vec_t v;
    v.s = s; v.has_word = hw; v.word = w; v.errs = e;
    vq.push_back(v);
  endtask

  function automatic int hex_val(input byte c);
    if (c >= "0" && c <= "9") return c - "0";
    if (c >= "a" && c <= "f") return c - "a" + 10;
    if (c >= "A" && c <= "F") return c - "A" + 10;
    return -1;
  endfunction

  task automatic model_char(input byte c);
    bit cmd;
    cmd = (c == "R") || (c == "W");
    if (!m_busy) begin
      if (cmd) begin m_busy = 1'b1; m_w = (c == "W"); m_nibs.delete(); end
    end else if (hex_val(c) >= 0) begin
      m_nibs.push_back(hex_val(c));
      if (m_nibs.size() == 8) begin
        logic [33:0] v;
        v = {1'b0, m_w, 32'h0};
        for (int i = 0; i < 8; i++) v[31:0] = v[31:0] * 16 + 32'(m_nibs[i]);
        exp_q.push_back(v);
        m_busy = 1'b0;
      end
    end else if (cmd) begin
      m_err++; m_w = (c == "W"); m_nibs.delete();
    end else begin
      m_err++; m_busy = 1'b0;
    end
  endtask

  task automatic run_char(input byte c, input int gap);
    model_char(c);
    send_char(c, gap);
    check("rand_busy", 64'(busy), 64'(m_busy));
  endtask

  task automatic check_errs(input string name);
    check({name, "_pulses"}, 64'(err_seen), 64'(m_err));
    check({name, "_errcnt"}, 64'(err_cnt), 64'(sat_cnt(m_err)));
  endtask

  initial begin
    string hexs;
    string junk;
    logic [33:0] held;
    int e0;

    hexs = "0123456789abcdefABCDEF";
    junk = "xgZ:\015\012 ";

    add_vec("W12345678", 1, 34'h1_12345678, 0);
    add_vec("\015\012RdeadBEEF\015\012", 1, 34'h0_DEADBEEF, 0);
    add_vec("W12x", 0, 34'h0, 1);
    add_vec("W12R00000001", 1, 34'h0_00000001, 1);
    add_vec("xyz 0123\012", 0, 34'h0, 0);
    add_vec("RW0000000F", 1, 34'h1_0000000F, 1);
    add_vec("W123456789", 1, 34'h1_12345678, 0);
    add_vec("Wabcdef01", 1, 34'h1_ABCDEF01, 0);
    add_vec("R0\012", 0, 34'h0, 1);
    add_vec("R0000000G", 0, 34'h0, 1);

    repeat (3) @(posedge clk);
    #1;
    check("reset_cyc", 64'(cyc), 64'h0);
    check("reset_word", 64'(word), 64'h0);
    check("reset_err", 64'(err), 64'h0);
    check("reset_errcnt", 64'(err_cnt), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    wait_cyc(2);

    // table-driven frames, characters back to back
    foreach (vq[k]) begin
      if (vq[k].has_word) exp_q.push_back(vq[k].word);
      m_err += vq[k].errs;
      send_str(vq[k].s);
      wait_cyc(3);
      check("vec_busy", 64'(busy), 64'h0);
      check("vec_drained", 64'(exp_q.size()), 64'h0);
      check_errs("vec");
    end

    // single frame: cyc one cycle, one clock after the last strobe
    exp_q.push_back(34'h1_12345678);
    send_str("W1234567");
    send_char("8", 0);
    check("t1_cyc_hi", 64'(cyc), 64'h1);
    check("t1_word", 64'(word), 64'h1_12345678);
    wait_cyc(1);
    check("t1_cyc_lo", 64'(cyc), 64'h0);

    // held word under stall, second frame dropped with one error
    stall = 1'b1;
    held = 34'h0_CAFE0123;
    exp_q.push_back(held);
    send_str("RCAFE0123");
    for (int i = 0; i < 20; i++) begin
      check("t3_stall_cyc", 64'(cyc), 64'h1);
      check("t3_stall_word", 64'(word), 64'(held));
      wait_cyc(1);
    end
    m_err += 1;
    send_str("W87654321");
    wait_cyc(2);
    check_errs("t3_drop");
    check("t3_held_word", 64'(word), 64'(held));
    stall = 1'b0;
    wait_cyc(1);
    check("t3_cyc_drop", 64'(cyc), 64'h0);
    check("t3_drained", 64'(exp_q.size()), 64'h0);

    // timeout inside a frame
    send_str("W123");
    e0 = err_seen;
    wait_cyc(TMO - 5);
    check("t5_no_early_err", 64'(err_seen - e0), 64'h0);
    check("t5_busy_waiting", 64'(busy), 64'h1);
    wait_cyc(15);
    m_err += 1;
    check_errs("t5_timeout");
    check("t5_busy", 64'(busy), 64'h0);
    exp_q.push_back(34'h0_0000000A);
    send_str("R0000000a");
    wait_cyc(3);
    check("t5_drained", 64'(exp_q.size()), 64'h0);

    // random character stream against the reference parser
    for (int n = 0; n < 300; n++) begin
      int cat;
      byte c;
      cat = $urandom_range(0, 99);
      if (cat < 60)      c = hexs[$urandom_range(0, hexs.len() - 1)];
      else if (cat < 80) c = ($urandom_range(0, 1) != 0) ? "W" : "R";
      else               c = junk[$urandom_range(0, junk.len() - 1)];
      run_char(c, $urandom_range(0, 3));
    end
    if (m_busy) run_char("x", 0);
    wait_cyc(3);
    check("rand_drained", 64'(exp_q.size()), 64'h0);
    check_errs("rand");

    // async reset mid-frame with a word pending
    stall = 1'b1;
    send_str("W11111111");
    send_str("W1234");
    check("t6_pre_busy", 64'(busy), 64'h1);
    check("t6_pre_cyc", 64'(cyc), 64'h1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_cyc", 64'(cyc), 64'h0);
    check("t6_rst_word", 64'(word), 64'h0);
    check("t6_rst_busy", 64'(busy), 64'h0);
    check("t6_rst_errcnt", 64'(err_cnt), 64'h0);
    check("t6_rst_err", 64'(err), 64'h0);
    exp_q.delete();
    m_err = 0;
    err_seen = 0;
    m_busy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    stall = 1'b0;
    exp_q.push_back(34'h1_0000FFFF);
    send_str("W0000FFFF");
    wait_cyc(3);
    check("t6_drained", 64'(exp_q.size()), 64'h0);
    check_errs("t6");

    // saturation of the error counter
    for (int i = 0; i < 300; i++) send_str("Wx");
    m_err += 300;
    wait_cyc(3);
    check_errs("sat");
    check("sat_ff", 64'(err_cnt), 64'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
